qam_mapper: RTL and testbench

Converts an input byte stream into 16-QAM constellation points for an 8-subcarrier OFDM transmitter. Bits are buffered in a carry-over register and emitted four at a time as signed I/Q pairs on an AXI-Stream-style output, framed into groups of N symbols. After each frame the block holds a fixed guard gap of CP cycles for downstream cyclic-prefix insertion. It sits between the byte source and the IFFT/CP stage.

---
 rtl/ofdm_pkg.sv | 31 +++
 rtl/qam16_lut.sv | 25 ++
 rtl/qam_mapper.sv | 177 +++++++++++++++++
 tb/tb_qam_mapper.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared constants, state encoding and constellation levels for the OFDM transmit path.
package ofdm_pkg;

  localparam int unsigned B     = 8;
  localparam int unsigned N     = 8;
  localparam int unsigned W     = 16;
  localparam int unsigned CP    = 4;
  localparam int          SCALE = 2048;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned IDX_W = 10;
  localparam int unsigned DLY_W = 4;
  localparam int unsigned LDC_W = 9;

  typedef enum logic {
    RUN = 1'b0,
    GAP = 1'b1
  } state_e;

  // Gray-coded 16-QAM amplitudes, two's complement at W bits
  localparam logic [W-1:0] L_M3 = W'(-3 * SCALE);
  localparam logic [W-1:0] L_M1 = W'(-1 * SCALE);
  localparam logic [W-1:0] L_P1 = W'(SCALE);
  localparam logic [W-1:0] L_P3 = W'(3 * SCALE);

  typedef struct packed {
    logic [W-1:0] i;
    logic [W-1:0] q;
  } iq_t;

endpackage

// File: rtl/qam16_lut.sv
// Combinational 16-QAM mapper: nibble b3b2 selects I, b1b0 selects Q (Gray coded).
module qam16_lut
  import ofdm_pkg::*;
(
  input  logic [3:0] nibble,
  output iq_t        iq_c
);

  function automatic logic [W-1:0] gray_level(input logic [1:0] bits);
    logic [W-1:0] lvl;
    case (bits)
      2'b00:   lvl = L_M3;
      2'b01:   lvl = L_M1;
      2'b11:   lvl = L_P1;
      default: lvl = L_P3;
    endcase
    return lvl;
  endfunction

  always_comb begin
    iq_c.i = gray_level(nibble[3:2]);
    iq_c.q = gray_level(nibble[1:0]);
  end

endmodule

// File: rtl/qam_mapper.sv
// Byte stream to framed 16-QAM symbols with a fixed guard gap after each frame.
// QAM_DEBUG_EN exposes the internal counters/accumulator on the debug ports.
module qam_mapper
  import ofdm_pkg::*;
(
  input  logic             aclk,
  input  logic             reset,
  input  logic [B-1:0]     s_data_in,
  input  logic             s_dvalid,
  output logic             s_dready,
  output logic [2*W-1:0]   m_data_out,
  input  logic             m_dready,
  output logic             m_dvalid,
  output logic             m_dlast,
  output logic [IDX_W-1:0] m_symbol_index,
  output logic             fft_valid,
  output logic [DLY_W-1:0] delay_c,
  output logic [ACC_W-1:0] carry_over,
  output logic [CNT_W-1:0] co_count,
  output logic [LDC_W-1:0] load_count,
  output logic             load_check
);

  state_e           state_q, state_d;
  logic             rdy_en_q;
  logic [ACC_W-1:0] carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             fft_q, fft_d;
  logic [DLY_W-1:0] delay_q, delay_d;

  logic             load_c, out_hs_c, last_hs_c, emit_c;
  logic [ACC_W-1:0] shifted_c, word_c;
  logic [CNT_W-1:0] base_cnt_c;
  iq_t              sym_c;

  qam16_lut u_lut (
    .nibble (carry_q[ACC_W-1 -: 4]),
    .iq_c   (sym_c)
  );

  // rdy_en_q keeps the input closed while reset is asserted
  assign s_dready = rdy_en_q & (state_q == RUN) & (cnt_q <= CNT_W'(ACC_W - B));

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    delay_d = delay_q;
    fft_d   = 1'b0;

    load_c    = s_dvalid & s_dready;
    out_hs_c  = valid_q & m_dready;
    last_hs_c = out_hs_c & last_q;
    // No new symbol on the closing beat: the frame ends and the gap starts
    emit_c    = (state_q == RUN) & (cnt_q >= CNT_W'(4)) & (~valid_q | m_dready) & ~last_hs_c;

    shifted_c  = emit_c ? (carry_q << 4) : carry_q;
    base_cnt_c = emit_c ? (cnt_q - CNT_W'(4)) : cnt_q;
    word_c     = {s_data_in, {(ACC_W - B){1'b0}}} >> base_cnt_c;

    if (load_c) begin
      carry_d = shifted_c | word_c;
      cnt_d   = base_cnt_c + CNT_W'(B);
    end else begin
      carry_d = shifted_c;
      cnt_d   = base_cnt_c;
    end

    if (last_hs_c) begin
      idx_d = '0;
    end else if (out_hs_c) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (emit_c) begin
      data_d  = sym_c;
      valid_d = 1'b1;
    end else if (out_hs_c) begin
      valid_d = 1'b0;
    end
    last_d = valid_d & (idx_d == IDX_W'(N - 1));

    case (state_q)
      RUN: begin
        if (last_hs_c) begin
          state_d = GAP;
          delay_d = '0;
          fft_d   = 1'b1;
        end
      end
      GAP: begin
        if (delay_q == DLY_W'(CP - 1)) begin
          state_d = RUN;
          delay_d = '0;
        end else begin
          delay_d = delay_q + DLY_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q  <= RUN;
      rdy_en_q <= 1'b0;
      carry_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      idx_q    <= '0;
      fft_q    <= 1'b0;
      delay_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      fft_q    <= fft_d;
      delay_q  <= delay_d;
    end
  end

  assign m_data_out     = data_q;
  assign m_dvalid       = valid_q;
  assign m_dlast        = last_q;
  assign m_symbol_index = idx_q;
  assign fft_valid      = fft_q;

`ifdef QAM_DEBUG_EN
  logic [LDC_W-1:0] ldcnt_q, ldcnt_d;
  logic             ldchk_q, ldchk_d;

  always_comb begin
    ldcnt_d = ldcnt_q;
    ldchk_d = load_c;
    if (load_c) begin
      ldcnt_d = ldcnt_q + LDC_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      ldcnt_q <= '0;
      ldchk_q <= 1'b0;
    end else begin
      ldcnt_q <= ldcnt_d;
      ldchk_q <= ldchk_d;
    end
  end

  assign delay_c    = delay_q;
  assign carry_over = carry_q;
  assign co_count   = cnt_q;
  assign load_count = ldcnt_q;
  assign load_check = ldchk_q;
`else
  assign delay_c    = '0;
  assign carry_over = '0;
  assign co_count   = '0;
  assign load_count = '0;
  assign load_check = 1'b0;
`endif

endmodule

// File: tb/tb_qam_mapper.sv
// Directed self-checking bench for qam_mapper: framing, guard gap, backpressure, reset.
module tb_qam_mapper;

`ifdef QAM_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic        aclk;
  logic        reset;
  logic [7:0]  s_data_in;
  logic        s_dvalid;
  logic        s_dready;
  logic [31:0] m_data_out;
  logic        m_dready;
  logic        m_dvalid;
  logic        m_dlast;
  logic [9:0]  m_symbol_index;
  logic        fft_valid;
  logic [3:0]  delay_c;
  logic [15:0] carry_over;
  logic [5:0]  co_count;
  logic [8:0]  load_count;
  logic        load_check;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_data[$];
  logic [9:0]  q_idx[$];
  logic        q_last[$];
  logic [31:0] exp_frame [8];

  qam_mapper dut (
    .aclk           (aclk),
    .reset          (reset),
    .s_data_in      (s_data_in),
    .s_dvalid       (s_dvalid),
    .s_dready       (s_dready),
    .m_data_out     (m_data_out),
    .m_dready       (m_dready),
    .m_dvalid       (m_dvalid),
    .m_dlast        (m_dlast),
    .m_symbol_index (m_symbol_index),
    .fft_valid      (fft_valid),
    .delay_c        (delay_c),
    .carry_over     (carry_over),
    .co_count       (co_count),
    .load_count     (load_count),
    .load_check     (load_check)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Record each beat that will complete a handshake on the coming rising edge
  always @(negedge aclk) begin
    #2;
    if (!reset && m_dvalid && m_dready) begin
      q_data.push_back(m_data_out);
      q_idx.push_back(m_symbol_index);
      q_last.push_back(m_dlast);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!s_dready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100) check("s_dready_wait", 64'(s_dready), 64'd1);
    s_data_in = b;
    s_dvalid  = 1'b1;
    @(negedge aclk);
    s_dvalid  = 1'b0;
    @(negedge aclk);
  endtask

  // Wait for the closing beat, then walk the guard gap and the return to RUN
  task automatic check_gap(input string tag);
    int n = 0;
    while (!(m_dvalid && m_dlast) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) check({tag, "_dlast_seen"}, 64'(m_dvalid & m_dlast), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check($sformatf("%s_gap%0d_s_dready", tag, i), 64'(s_dready), 64'd0);
      check($sformatf("%s_gap%0d_m_dvalid", tag, i), 64'(m_dvalid), 64'd0);
      check($sformatf("%s_gap%0d_delay_c", tag, i), 64'(delay_c), DBG ? 64'(i) : 64'd0);
      check($sformatf("%s_gap%0d_fft_valid", tag, i), 64'(fft_valid), (i == 0) ? 64'd1 : 64'd0);
    end
    @(negedge aclk);
    check({tag, "_resume_s_dready"}, 64'(s_dready), 64'd1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_beats"}, 64'(q_data.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < q_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), 64'(q_data[i]), 64'(exp_frame[i]));
        check($sformatf("%s_idx%0d", tag, i), 64'(q_idx[i]), 64'(i));
        check($sformatf("%s_last%0d", tag, i), 64'(q_last[i]), (i == 7) ? 64'd1 : 64'd0);
      end
    end
    q_data.delete();
    q_idx.delete();
    q_last.delete();
  endtask

  initial begin
    reset     = 1'b1;
    s_data_in = 8'h00;
    s_dvalid  = 1'b0;
    m_dready  = 1'b1;

    repeat (5) @(negedge aclk);
    check("rst_data", 64'(m_data_out), 64'd0);
    check("rst_valid", 64'(m_dvalid), 64'd0);
    check("rst_last", 64'(m_dlast), 64'd0);
    check("rst_idx", 64'(m_symbol_index), 64'd0);
    check("rst_fft", 64'(fft_valid), 64'd0);
    check("rst_delay", 64'(delay_c), 64'd0);
    check("rst_carry", 64'(carry_over), 64'd0);
    check("rst_co_count", 64'(co_count), 64'd0);
    check("rst_load_count", 64'(load_count), 64'd0);
    check("rst_load_check", 64'(load_check), 64'd0);
    check("rst_s_dready", 64'(s_dready), 64'd0);

    reset = 1'b0;
    @(negedge aclk);
    check("rel_s_dready", 64'(s_dready), 64'd1);
    check("rel_co_count", 64'(co_count), 64'd0);

    // Frame 1: nibbles 0..7; first byte driven by hand to observe latency
    exp_frame = '{32'hE800E800, 32'hE800F800, 32'hE8001800, 32'hE8000800,
                  32'hF800E800, 32'hF800F800, 32'hF8001800, 32'hF8000800};
    s_data_in = 8'h01;
    s_dvalid  = 1'b1;
    @(negedge aclk);
    s_dvalid = 1'b0;
    check("lat1_m_dvalid", 64'(m_dvalid), 64'd0);
    check("lat1_load_check", 64'(load_check), DBG ? 64'd1 : 64'd0);
    check("lat1_co_count", 64'(co_count), DBG ? 64'd8 : 64'd0);
    @(negedge aclk);
    check("lat2_m_dvalid", 64'(m_dvalid), 64'd1);
    check("lat2_data", 64'(m_data_out), 64'hE800E800);
    send_byte(8'h23);
    send_byte(8'h45);
    send_byte(8'h67);
    check_gap("f1");
    check_frame("f1");
    check("f1_load_count", 64'(load_count), DBG ? 64'd4 : 64'd0);

    // Frame 2: same bytes, same symbols
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h45);
    send_byte(8'h67);
    check_gap("f2");
    check_frame("f2");
    check("f2_load_count", 64'(load_count), DBG ? 64'd8 : 64'd0);

    // Frame 3: fill the accumulator under 5 cycles of backpressure
    exp_frame = '{32'h08000800, 32'hE800E800, 32'h18001800, 32'h08000800,
                  32'hE8001800, 32'hE8000800, 32'hF800F800, 32'h18001800};
    s_data_in = 8'hF0;
    s_dvalid  = 1'b1;
    @(negedge aclk);
    s_dvalid = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    check("bp_pre_valid", 64'(m_dvalid), 64'd1);
    check("bp_pre_idx", 64'(m_symbol_index), 64'd1);
    check("bp_pre_data", 64'(m_data_out), 64'hE800E800);
    m_dready  = 1'b0;
    s_data_in = 8'hAF;
    s_dvalid  = 1'b1;
    @(negedge aclk);
    check("bp_co8", 64'(co_count), DBG ? 64'd8 : 64'd0);
    check("bp_carry_af", 64'(carry_over), DBG ? 64'hAF00 : 64'd0);
    check("bp_ready_at8", 64'(s_dready), 64'd1);
    s_data_in = 8'h23;
    @(negedge aclk);
    s_dvalid = 1'b0;
    check("bp_co16", 64'(co_count), DBG ? 64'd16 : 64'd0);
    check("bp_carry_full", 64'(carry_over), DBG ? 64'hAF23 : 64'd0);
    check("bp_ready_full", 64'(s_dready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_hold%0d_data", i), 64'(m_data_out), 64'hE800E800);
      check($sformatf("bp_hold%0d_idx", i), 64'(m_symbol_index), 64'd1);
      check($sformatf("bp_hold%0d_valid", i), 64'(m_dvalid), 64'd1);
      check($sformatf("bp_hold%0d_last", i), 64'(m_dlast), 64'd0);
      @(negedge aclk);
    end
    m_dready = 1'b1;
    send_byte(8'h5A);
    check_gap("f3");
    check_frame("f3");

    // Reset mid-frame discards buffered bits and the frame position
    s_data_in = 8'hF0;
    s_dvalid  = 1'b1;
    @(negedge aclk);
    s_dvalid = 1'b0;
    @(negedge aclk);
    reset = 1'b1;
    @(negedge aclk);
    check("mid_rst_valid", 64'(m_dvalid), 64'd0);
    check("mid_rst_idx", 64'(m_symbol_index), 64'd0);
    check("mid_rst_co_count", 64'(co_count), 64'd0);
    check("mid_rst_s_dready", 64'(s_dready), 64'd0);
    reset = 1'b0;
    @(negedge aclk);
    check("post_rst_s_dready", 64'(s_dready), 64'd1);
    check("post_rst_valid", 64'(m_dvalid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
